// File: rtl/exc_pkg.sv
// Shared definitions for the exception-tracking pipeline: cause codes and the
// per-stage record carried alongside each instruction.
package exc_pkg;

  // Widths the stage record is built with; exc_pipe parameters default to these.
  localparam int unsigned REC_ADDR_W = 32;
  localparam int unsigned REC_CODE_W = 5;

  localparam logic [REC_CODE_W-1:0] EXC_INT  = 5'd0;
  localparam logic [REC_CODE_W-1:0] EXC_ADEL = 5'd4;
  localparam logic [REC_CODE_W-1:0] EXC_ADES = 5'd5;
  localparam logic [REC_CODE_W-1:0] EXC_RI   = 5'd10;
  localparam logic [REC_CODE_W-1:0] EXC_OV   = 5'd12;

  typedef struct packed {
    logic                  valid;
    logic [REC_ADDR_W-1:0] pc;
    logic                  bd;
    logic                  pend;
    logic [REC_CODE_W-1:0] code;
  } stage_t;

endpackage

// File: rtl/exc_pipe_if.sv
// Bundle of fetch inputs, per-stage raises, interrupt/eret controls and the
// commit-stage results of the exception pipeline.
interface exc_pipe_if #(
  parameter int unsigned STAGES = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CODE_W = 5,
  parameter int unsigned INT_N  = 6
);

  logic                     stall;
  logic                     in_valid;
  logic [ADDR_W-1:0]        in_pc;
  logic                     in_bd;
  logic                     in_raise;
  logic [CODE_W-1:0]        in_code;
  logic [STAGES-1:0]        st_raise;
  logic [STAGES*CODE_W-1:0] st_code;
  logic                     eret_commit;
  logic [INT_N-1:0]         int_req;
  logic [INT_N-1:0]         int_mask;
  logic                     ie;
  logic                     exc_take;
  logic [CODE_W-1:0]        exc_code;
  logic [ADDR_W-1:0]        exc_epc;
  logic                     exc_bd;
  logic                     flush;
  logic                     eret_take;
  logic                     exl;

  modport master (
    output stall, in_valid, in_pc, in_bd, in_raise, in_code, st_raise, st_code,
    output eret_commit, int_req, int_mask, ie,
    input  exc_take, exc_code, exc_epc, exc_bd, flush, eret_take, exl
  );

  modport slave (
    input  stall, in_valid, in_pc, in_bd, in_raise, in_code, st_raise, st_code,
    input  eret_commit, int_req, int_mask, ie,
    output exc_take, exc_code, exc_epc, exc_bd, flush, eret_take, exl
  );

endinterface

// File: rtl/exc_stage_merge.sv
// Folds one stage's raise into the record it currently holds; an already
// pending code is never overwritten so the earliest exception wins.
module exc_stage_merge
  import exc_pkg::*;
(
  input  stage_t                cur,
  input  logic                  raise,
  input  logic [REC_CODE_W-1:0] code,
  output stage_t                merged
);

  // Raises against bubbles or already-faulted instructions are dropped.
  always_comb begin
    merged = cur;
    if (!cur.pend && cur.valid && raise) begin
      merged.pend = 1'b1;
      merged.code = code;
    end
  end

endmodule

// File: rtl/exc_pipe.sv
// Exception-tracking pipeline: carries PC/BD/first exception code through
// STAGES registers, arbitrates against interrupts at commit and tracks EXL.
module exc_pipe
  import exc_pkg::*;
#(
  parameter int unsigned STAGES = 4,
  parameter int unsigned ADDR_W = REC_ADDR_W,
  parameter int unsigned CODE_W = REC_CODE_W,
  parameter int unsigned INT_N  = 6
) (
  input  logic       clk,
  input  logic       reset,
  exc_pipe_if.slave  bus
);

  stage_t stage_q [STAGES];
  stage_t stage_d [STAGES];
  stage_t merged  [STAGES];
  stage_t in_rec;
  stage_t commit;

  logic exl_q, exl_d;
  logic int_hit, exc_take, eret_take, flush;

  for (genvar s = 0; s < STAGES; s++) begin : g_merge
    exc_stage_merge u_merge (
      .cur    (stage_q[s]),
      .raise  (bus.st_raise[s]),
      .code   (bus.st_code[s*CODE_W +: CODE_W]),
      .merged (merged[s])
    );
  end

  // Fetch-side record; a fetch raise starts the instruction already pending.
  always_comb begin
    in_rec       = '0;
    in_rec.valid = bus.in_valid;
    in_rec.pc    = bus.in_pc;
    in_rec.bd    = bus.in_bd;
    in_rec.pend  = bus.in_valid & bus.in_raise;
    in_rec.code  = in_rec.pend ? bus.in_code : '0;
  end

  // Commit arbitration: interrupt beats a pending exception, which beats eret.
  always_comb begin
    commit    = merged[STAGES-1];
    int_hit   = bus.ie & ~exl_q & (|(bus.int_req & bus.int_mask)) & commit.valid;
    exc_take  = int_hit | (commit.valid & commit.pend);
    eret_take = ~exc_take & bus.eret_commit & exl_q;
    flush     = exc_take | eret_take;
  end

  // Stage advance; a stalled stage 0 keeps its merged record so raises stick.
  always_comb begin
    stage_d[0] = bus.stall ? merged[0] : in_rec;
    for (int s = 1; s < STAGES; s++) begin
      stage_d[s] = merged[s-1];
    end
    if (bus.stall) begin
      stage_d[1] = '0;
    end
    if (flush) begin
      for (int s = 0; s < STAGES; s++) begin
        stage_d[s] = '0;
      end
    end
  end

  // EXL enters on any exception/interrupt entry and leaves on an accepted eret.
  always_comb begin
    exl_d = exl_q;
    if (exc_take) begin
      exl_d = 1'b1;
    end else if (eret_take) begin
      exl_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < STAGES; s++) begin
        stage_q[s] <= '0;
      end
      exl_q <= 1'b0;
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        stage_q[s] <= stage_d[s];
      end
      exl_q <= exl_d;
    end
  end

  // Cause/EPC outputs are forced to zero unless an entry is happening.
  always_comb begin
    bus.exc_take  = exc_take;
    bus.eret_take = eret_take;
    bus.flush     = flush;
    bus.exl       = exl_q;
    bus.exc_code  = '0;
    bus.exc_epc   = '0;
    bus.exc_bd    = 1'b0;
    if (exc_take) begin
      bus.exc_code = int_hit ? EXC_INT : commit.code;
      bus.exc_epc  = commit.bd ? (commit.pc - ADDR_W'(4)) : commit.pc;
      bus.exc_bd   = commit.bd;
    end
  end

endmodule

// File: doc/exc_pipe.md
# exc_pipe

Parametrised exception-tracking pipeline for the MIPS core. Carries each instruction's PC, delay-slot flag and first-raised exception code through `STAGES` pipeline registers and merges in codes raised by later stages, keeping the earliest. At the commit stage it arbitrates against masked hardware interrupts, signals exception entry and flush, and tracks the EXL state with exit on `eret`. It replaces per-stage, stateless exception-code forwarding in the datapath.

## Interface
- `STAGES`, 4, number of tracked stages (D, E, M, W); index 0 is the youngest, `STAGES-1` is commit. Minimum 2.
- `ADDR_W`, 32, PC width.
- `CODE_W`, 5, exception-code width.
- `INT_N`, 6, hardware interrupt lines.

Ports:
- `clk`, in, 1, clock. One clock domain.
- `reset`, in, 1, reset; synchronous, active-high.
- `stall`, in, 1, hold stage 0 and insert a bubble into stage 1.
- `in_valid`, in, 1, fetch stage presents an instruction.
- `in_pc`, in, `ADDR_W`, PC of that instruction.
- `in_bd`, in, 1, instruction sits in a branch delay slot.
- `in_raise`, in, 1, fetch raised an exception.
- `in_code`, in, `CODE_W`, fetch exception code, e.g. AdEL = 4.
- `st_raise`, in, `STAGES`, stage s raises an exception for its current instruction.
- `st_code`, in, `STAGES*CODE_W`, code for stage s in slice s.
- `eret_commit`, in, 1, a valid `eret` is at the commit stage.
- `int_req`, in, `INT_N`, level-sensitive interrupt requests.
- `int_mask`, in, `INT_N`, IM bits.
- `ie`, in, 1, global interrupt enable.
- `exc_take`, out, 1, exception or interrupt entry this cycle.
- `exc_code`, out, `CODE_W`, cause code; 0 for interrupt.
- `exc_epc`, out, `ADDR_W`, restart PC.
- `exc_bd`, out, 1, BD bit for Cause.
- `flush`, out, 1, kill all in-flight instructions; equals `exc_take | eret_take`.
- `eret_take`, out, 1, `eret` accepted.
- `exl`, out, 1, exception level.

## Operation
- Each stage register holds `valid`, `pc`, `bd`, `pend`, `code`.
- Stage 0 loads `in_*` when `stall`=0 and holds when `stall`=1.
- Stage s+1 loads the merged value of stage s, except when stage s+1 = 1 and `stall`=1; then stage 1 loads a bubble (`valid`=0, `pend`=0).
- Merge rule, applied at every stage including commit: if `pend`=0 and `valid` and `st_raise[s]`, set `pend`=1 and `code`=`st_code[s]`. Otherwise the existing code is kept, so the first-raised code wins.
- Raises on a bubble are ignored.
- Commit evaluation is combinational from the commit register plus the commit-stage merge:
  - `int_hit` = `ie & ~exl & |(int_req & int_mask)` & commit `valid`.
  - If `int_hit`: `exc_take`=1 and `exc_code`=0. Interrupt has priority over a pending exception.
  - Else if merged `pend` (commit `valid`): `exc_take`=1 and `exc_code`=merged code.
  - Else if `eret_commit` & `exl`: `eret_take`=1.
  - `eret_commit` with `exl`=0 is ignored and raises no flush.
- `exc_epc` = commit `pc` − 4 when commit `bd`=1, else commit `pc`. `exc_bd` = commit `bd`. Subtraction wraps modulo 2^`ADDR_W`.
- When `exc_take` is 0, `exc_code`, `exc_epc` and `exc_bd` are 0.
- A new exception during `exl`=1 is still taken and `exl` stays 1. Only interrupts are gated by `exl`.

## Timing
- Reset:
  - All stages `valid`=0, `pend`=0, `pc`=0, `bd`=0, `code`=0.
  - `exl`=0.
  - All outputs are 0 on the cycle after reset.
- Latency: an instruction accepted with `stall`=0 reaches commit `STAGES` edges later, plus one edge per cycle it is stalled at stage 0.
- `exc_take`, `eret_take` and `flush` are combinational in the commit cycle.
- On the following edge:
  - All stage registers are cleared, overriding `stall` and `in_valid`.
  - `exl` is set on `exc_take` or cleared on `eret_take`.
- Flush and reset in the same cycle: reset wins; identical result.
- `exc_take` and `eret_take` are never both 1.
- Interrupts with commit bubbles wait for the next valid instruction at commit.

## Structure
- Shared package `exc_pkg` holds:
  - Code constants: `EXC_INT`=0, `EXC_ADEL`=4, `EXC_ADES`=5, `EXC_RI`=10, `EXC_OV`=12.
  - The stage-record typedef {`valid`, `pc`, `bd`, `pend`, `code`}.
- Sub-module `exc_stage_merge`: the combinational merge for one stage, instantiated `STAGES` times through generate.

## Test plan
- Straight flow, `STAGES`=4: pc 0x3000, `st_raise[1]`=1 with code 10 → `exc_take`=1 four edges later, `exc_code`=10, `exc_epc`=0x3000, `flush`=1; all stages invalid on the next cycle; `exl`=1.
- First-wins: `in_raise` with code 4, then `st_raise[2]` with code 12 on the same instruction → `exc_code`=4.
- Delay slot: `in_bd`=1, pc 0x3010, raise code 12 → `exc_epc`=0x300C, `exc_bd`=1.
- Interrupt priority: `ie`=1, `int_req`=6'b000100, `int_mask`=6'b000100, and a commit instruction with pending code 10 → `exc_code`=0. Same stimulus with `exl`=1 → code 10 taken and `exl` stays 1.
- `eret`: `exl`=1 with `eret_commit` → `eret_take`=1, `flush`=1, `exl`=0 next cycle. The same stimulus with `exl`=0 → no flush.
- Stall plus reset: hold `stall` 3 cycles → stage 0 holds and 3 bubbles reach commit with no take. Assert `reset` mid-flight → all outputs 0 next cycle.
